// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: fetch PC sequencing, late branch resolution with NZVC flags,
// and a counted flush of wrong-path fetches after a taken branch
module fetch_branch_unit #(
   parameter int ADDR_WIDTH = 64,
   parameter int OFFSET_WIDTH = 26,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    br_valid,
   input  logic [1:0]              br_type,
   input  logic [3:0]              br_cond,
   input  logic [ADDR_WIDTH-1:0]   br_pc,
   input  logic [OFFSET_WIDTH-1:0] br_offset,
   input  logic                    cb_zero,
   input  logic                    flags_wr_en,
   input  logic [3:0]              flags_in,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic                    fetch_valid,
   output logic                    flush,
   output logic                    br_taken,
   output logic [ADDR_WIDTH-1:0]   br_target,
   output logic [3:0]              flags_q
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t state;
   logic [3:0] cnt;
   logic [3:0] eff;
   logic base, cond_true;
   assign eff = flags_wr_en ? flags_in : flags_q;
   // eff = {N,Z,V,C}; odd condition codes are the inverse of the even one below them
   always_comb begin
      case (br_cond[3:1])
         3'd0: base = eff[2];
         3'd1: base = eff[0];
         3'd2: base = eff[3];
         3'd3: base = eff[1];
         3'd4: base = eff[0] & ~eff[2];
         3'd5: base = eff[3] == eff[1];
         3'd6: base = ~eff[2] & (eff[3] == eff[1]);
         default: base = 1'b1;
      endcase
   end
   assign cond_true = br_type == 2'd0 ? 1'b1 :
                      br_type == 2'd1 ? (&br_cond[3:1] ? 1'b1 : base ^ br_cond[0]) :
                      br_type == 2'd2 ? cb_zero : ~cb_zero;
   assign br_taken = br_valid && cond_true && state == RUN;
   assign br_target = br_pc + (ADDR_WIDTH'($signed(br_offset)) << 2);
   assign flush = state == FLUSH;
   assign fetch_valid = state == RUN && !stall;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
         flags_q <= '0;
         state <= RUN;
         cnt <= '0;
      end else begin
         if (flags_wr_en) flags_q <= flags_in;
         pc <= br_taken ? br_target : stall ? pc : pc + ADDR_WIDTH'(4);
         if (br_taken) begin
            state <= FLUSH;
            cnt <= 4'(FLUSH_CYCLES - 1);
         end else if (state == FLUSH) begin
            if (cnt == '0) state <= RUN;
            else cnt <= cnt - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb_fetch_branch_unit: directed checks of PC sequencing, branch resolution, flags and flush
module tb_fetch_branch_unit;
   logic clk = 0, reset = 1, stall = 0, br_valid = 0, cb_zero = 0, flags_wr_en = 0;
   logic [1:0] br_type = 0;
   logic [3:0] br_cond = 0, flags_in = 0, flags_q;
   logic [63:0] br_pc = 0, pc, br_target;
   logic [25:0] br_offset = 0;
   logic fetch_valid, flush, br_taken;
   int total = 0, bad = 0;
   logic [3:0] tc [17] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h8, 4'h9, 4'hA, 4'hA, 4'hC, 4'hC, 4'hD, 4'hF};
   logic [3:0] tf [17] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0001, 4'b0101, 4'b0101, 4'b1010, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
   logic te [17] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1};
   fetch_branch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
      .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset), .cb_zero(cb_zero),
      .flags_wr_en(flags_wr_en), .flags_in(flags_in), .pc(pc), .fetch_valid(fetch_valid),
      .flush(flush), .br_taken(br_taken), .br_target(br_target), .flags_q(flags_q)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      step();
      chk("rst_pc", pc, 0);
      chk("rst_flush", flush, 0);
      chk("rst_flags", flags_q, 0);
      @(negedge clk);
      reset = 0;
      chk("t1_pc0", pc, 0);
      chk("t1_fv", fetch_valid, 1);
      step(); chk("t1_pc4", pc, 4);
      step(); chk("t1_pc8", pc, 8);
      chk("t1_flush", flush, 0);
      stall = 1;
      #1 chk("t2_fv", fetch_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step(); chk("t2_hold", pc, 8);
      end
      stall = 0;
      step(); chk("t2_pc12", pc, 12);
      br_valid = 1; br_type = 0; br_pc = 64'h10; br_offset = -26'sd2;
      #1 chk("t3_tgt", br_target, 8);
      chk("t3_taken", br_taken, 1);
      step(); chk("t3_pc", pc, 8);
      chk("t3_flush1", flush, 1);
      chk("t3_fv1", fetch_valid, 0);
      br_valid = 0;
      step(); chk("t3_pc2", pc, 12);
      chk("t3_flush2", flush, 1);
      step(); chk("t3_pc3", pc, 16);
      chk("t3_flush3", flush, 0);
      chk("t3_fv3", fetch_valid, 1);
      br_valid = 1; br_type = 1; br_cond = 4'hB; br_pc = 64'h100; br_offset = 26'd4;
      flags_wr_en = 1; flags_in = 4'b1000;
      #1 chk("t4_lt_taken", br_taken, 1);
      step(); chk("t4_pc", pc, 64'h110);
      chk("t4_flags", flags_q, 4'b1000);
      br_valid = 0; flags_wr_en = 0;
      step(); chk("t4_pc2", pc, 64'h114);
      step(); chk("t4_pc3", pc, 64'h118);
      chk("t4_flush", flush, 0);
      br_valid = 1; flags_wr_en = 1; flags_in = 4'b1010;
      #1 chk("t4_lt_nt", br_taken, 0);
      step(); chk("t4_pc4", pc, 64'h11C);
      chk("t4_flags2", flags_q, 4'b1010);
      flags_wr_en = 0; br_type = 3; cb_zero = 1;
      #1 chk("t5_cbnz", br_taken, 0);
      br_type = 2; stall = 1; br_pc = 64'h200; br_offset = 26'd8;
      #1 chk("t5_cbz", br_taken, 1);
      chk("t5_tgt", br_target, 64'h220);
      step(); chk("t5_pc", pc, 64'h220);
      chk("t5_flush", flush, 1);
      br_type = 0; br_pc = 64'h400; br_offset = 0; stall = 0;
      #1 chk("t6_ign", br_taken, 0);
      step(); chk("t6_pc1", pc, 64'h224);
      chk("t6_flush1", flush, 1);
      br_valid = 0;
      step(); chk("t6_pc2", pc, 64'h228);
      chk("t6_flush2", flush, 0);
      br_valid = 1; br_pc = 64'h300; br_offset = 26'h10;
      step(); chk("t6_pc3", pc, 64'h340);
      chk("t6_flush3", flush, 1);
      br_valid = 0;
      #1 reset = 1;
      #1 chk("t6_rst_pc", pc, 0);
      chk("t6_rst_flush", flush, 0);
      chk("t6_rst_flags", flags_q, 0);
      @(negedge clk);
      reset = 0;
      step(); chk("t6_after", pc, 4);
      chk("t6_fv", fetch_valid, 1);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         br_valid = 1; br_type = 1; br_cond = tc[i]; flags_wr_en = 1; flags_in = tf[i];
         #1 chk($sformatf("cond_%0h_%b", tc[i], tf[i]), br_taken, te[i]);
         br_valid = 0; flags_wr_en = 0;
      end
      @(negedge clk);
      br_valid = 1; br_type = 0; br_pc = 64'hFFFF_FFFF_FFFF_FFFC; br_offset = 26'd2;
      #1 chk("t7_tgt", br_target, 4);
      chk("t7_taken", br_taken, 1);
      step(); chk("t7_pc", pc, 4);
      chk("t7_flush", flush, 1);
      br_valid = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
